generic_ram_pipe: RTL and testbench

- Single-port synchronous RAM with a pipelined read path. Successor to the team's combinational-read RAM primitives.
- Adds per-byte write enables, configurable read latency (1..4), a valid/ready request handshake, and an optional hardware clear sweep after reset.
- Sits between the core's load/store unit or fetch logic and on-chip storage; timing-friendly for FPGA block RAM inference.

---
 rtl/generic_ram_pipe.sv | 169 ++++++++++++++++
 tb/tb_generic_ram_pipe.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/generic_ram_pipe.sv
// Single-port RAM, fully pipelined read (RD_LAT 1..4), per-byte write enables; no response backpressure,
// req_ready low only during the post-reset clear sweep. Optional per-byte parity via `define RAM_PARITY_EN.
module generic_ram_pipe #(
  parameter int    WIDTH          = 32,
  parameter int    DEPTH          = 256,
  parameter int    RD_LAT         = 1,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string DATAFILE       = ""
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [WIDTH/8-1:0]       req_be,
  input  logic [WIDTH-1:0]         req_wdata,
  input  logic                     err_inject,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     rsp_perr,
  output logic                     init_busy
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              NB      = WIDTH / 8;
  localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             clr_we, acc, addr_ok, rd_acc;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [NB-1:0]    mem_be;
  logic [WIDTH-1:0] mem_wdat, rd_dat;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] vld_q, vld_d, fv;
  logic [WIDTH-1:0]  dat_q [RD_LAT];
  logic [WIDTH-1:0]  dat_d [RD_LAT];
  logic [WIDTH-1:0]  fd    [RD_LAT];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    init_busy = 1'b0;
    clr_we    = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        init_busy = 1'b1;
        clr_we    = 1'b1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: req_ready = 1'b1;
    endcase
  end

  // Addresses past DEPTH exist only when DEPTH is not a power of two.
  always_comb begin
    acc      = req_valid && req_ready;
    addr_ok  = {1'b0, req_addr} < DEPTH_L;
    rd_acc   = acc && !req_we;
    rd_dat   = addr_ok ? mem[req_addr] : '0;
    mem_we   = 1'b0;
    mem_addr = req_addr;
    mem_be   = req_be;
    mem_wdat = req_wdata;
    if (clr_we) begin
      mem_we   = 1'b1;
      mem_addr = cnt_q;
      mem_be   = '1;
      mem_wdat = '0;
    end else if (acc && req_we && addr_ok) begin
      mem_we = 1'b1;
    end
  end

`ifdef RAM_PARITY_EN
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] mem_wpar, rd_par;
  logic [NB-1:0] par_q [RD_LAT];
  logic [NB-1:0] par_d [RD_LAT];
  logic [NB-1:0] fp    [RD_LAT];
  logic          perr_q, perr_d;

  function automatic logic [NB-1:0] byte_par(input logic [WIDTH-1:0] d);
    logic [NB-1:0] p;
    for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  always_comb begin
    mem_wpar = clr_we ? '0 : (byte_par(req_wdata) ^ {NB{err_inject}});
    rd_par   = addr_ok ? par_mem[req_addr] : '0;
    fp[0]    = rd_par;
    for (int i = 1; i < RD_LAT; i++) fp[i] = par_q[i-1];
    for (int i = 0; i < RD_LAT; i++) par_d[i] = fv[i] ? fp[i] : par_q[i];
    perr_d = fv[RD_LAT-1] && (byte_par(fd[RD_LAT-1]) != fp[RD_LAT-1]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) par_q[i] <= '0;
    end else begin
      perr_q <= perr_d;
      for (int i = 0; i < RD_LAT; i++) par_q[i] <= par_d[i];
    end
  end

  assign rsp_perr = perr_q;
`else
  logic unused_err;
  assign unused_err = err_inject;
  assign rsp_perr   = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_wdat[8*i +: 8];
`ifdef RAM_PARITY_EN
          par_mem[mem_addr][i] <= mem_wpar[i];
`endif
        end
      end
    end
  end

  // Stage 0 captures the array at the accept edge; the last stage is the response register.
  always_comb begin
    fv[0] = rd_acc;
    fd[0] = rd_dat;
    for (int i = 1; i < RD_LAT; i++) begin
      fv[i] = vld_q[i-1];
      fd[i] = dat_q[i-1];
    end
    for (int i = 0; i < RD_LAT; i++) begin
      vld_d[i] = fv[i];
      dat_d[i] = fv[i] ? fd[i] : dat_q[i];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
      vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      for (int i = 0; i < RD_LAT; i++) dat_q[i] <= dat_d[i];
    end
  end

  assign rsp_valid = vld_q[RD_LAT-1];
  assign rsp_rdata = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_generic_ram_pipe.sv
// Two instances share one request stream: A (DEPTH 256, RD_LAT 2) and B (DEPTH 200, RD_LAT 3).
module tb_generic_ram_pipe;
  localparam int LA = 2;
  localparam int LB = 3;
`ifdef RAM_PARITY_EN
  localparam logic PE = 1'b1;
`else
  localparam logic PE = 1'b0;
`endif

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, err_inject = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rdy_a, vld_a, perr_a, busy_a, rdy_b, vld_b, perr_b, busy_b;
  logic [31:0] rdat_a, rdat_b;

  generic_ram_pipe #(.WIDTH(32), .DEPTH(256), .RD_LAT(LA), .CLEAR_ON_RESET(1)) u_a (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_a),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .err_inject(err_inject), .rsp_valid(vld_a), .rsp_rdata(rdat_a), .rsp_perr(perr_a),
    .init_busy(busy_a));

  generic_ram_pipe #(.WIDTH(32), .DEPTH(200), .RD_LAT(LB), .CLEAR_ON_RESET(1)) u_b (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(rdy_b),
    .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .err_inject(err_inject), .rsp_valid(vld_b), .rsp_rdata(rdat_b), .rsp_perr(perr_b),
    .init_busy(busy_b));

  always #5 clock = ~clock;

  typedef struct { logic [31:0] dat; logic perr; int cyc; } exp_t;
  typedef struct {
    logic we; logic [7:0] addr; logic [3:0] be; logic [31:0] wd; logic err;
    logic [31:0] ea; logic [31:0] eb; logic pe; int gap;
  } vec_t;

  int          total = 0, bad = 0, cyc = 0;
  exp_t        qa[$], qb[$];
  exp_t        ea, eb;
  logic [31:0] exp_a = '0, exp_b = '0;
  logic        pe_row = 1'b0;
  vec_t        vt[$];
  int          ca, cb, nv, nr, win;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, want);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_rdy_a"}, rdy_a, 1'b0);   chk1({tag, "_rdy_b"}, rdy_b, 1'b0);
    chk1({tag, "_busy_a"}, busy_a, 1'b1); chk1({tag, "_busy_b"}, busy_b, 1'b1);
    chk1({tag, "_vld_a"}, vld_a, 1'b0);   chk1({tag, "_vld_b"}, vld_b, 1'b0);
    chk1({tag, "_perr_a"}, perr_a, 1'b0); chk1({tag, "_perr_b"}, perr_b, 1'b0);
    chk({tag, "_rdat_a"}, rdat_a, 32'h0); chk({tag, "_rdat_b"}, rdat_b, 32'h0);
  endtask

  // Releases reset and samples once per cycle until both sweeps end or max_edges elapse.
  task automatic run_sweep(input int max_edges, output int sa, output int sb,
                           output int bad_vld, output int bad_rdy);
    sa = 0; sb = 0; bad_vld = 0; bad_rdy = 0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int n = 0; n <= max_edges; n++) begin
      if (busy_a) sa++;
      if (busy_b) sb++;
      if (vld_a && busy_a) bad_vld++;
      if (vld_b && busy_b) bad_vld++;
      if ((rdy_a && busy_a) || (rdy_b && busy_b)) bad_rdy++;
      if ((!busy_a && !busy_b) || n == max_edges) break;
      @(negedge clock);
    end
  endtask

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset_n && req_valid && !req_we) begin
      if (rdy_a) qa.push_back('{exp_a, pe_row, cyc + LA});
      if (rdy_b) qb.push_back('{exp_b, pe_row, cyc + LB});
    end
  end

  always @(negedge reset_n) begin
    qa.delete();
    qb.delete();
  end

  always @(negedge clock) begin
    if (vld_a) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_a_unexpected: got valid data %0h want no response", rdat_a);
      end else begin
        ea = qa.pop_front();
        chk("rsp_a_data", rdat_a, ea.dat);
        chk1("rsp_a_perr", perr_a, ea.perr);
        chk("rsp_a_cycle", cyc, ea.cyc);
      end
    end else if (qa.size() != 0 && qa[0].cyc <= cyc) begin
      total++; bad++;
      $display("FAIL rsp_a_missing: got no valid at cycle %0d want data %0h", cyc, qa[0].dat);
      void'(qa.pop_front());
    end
    if (vld_b) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL rsp_b_unexpected: got valid data %0h want no response", rdat_b);
      end else begin
        eb = qb.pop_front();
        chk("rsp_b_data", rdat_b, eb.dat);
        chk1("rsp_b_perr", perr_b, eb.perr);
        chk("rsp_b_cycle", cyc, eb.cyc);
      end
    end else if (qb.size() != 0 && qb[0].cyc <= cyc) begin
      total++; bad++;
      $display("FAIL rsp_b_missing: got no valid at cycle %0d want data %0h", cyc, qb[0].dat);
      void'(qb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //           we    addr    be     wdata         err   exp_a         exp_b         pe    gap
    vt.push_back('{1'b1, 8'd5,   4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b1, 8'd5,   4'h3, 32'h00001234, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b0, 8'd5,   4'h0, 32'h0,        1'b0, 32'hDEAD1234, 32'hDEAD1234, 1'b0, 4});
    vt.push_back('{1'b1, 8'd1,   4'hF, 32'h11,       1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b1, 8'd2,   4'hF, 32'h22,       1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b1, 8'd3,   4'hF, 32'h33,       1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b1, 8'd4,   4'hF, 32'h44,       1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b0, 8'd1,   4'h0, 32'h0,        1'b0, 32'h11,       32'h11,       1'b0, 0});
    vt.push_back('{1'b0, 8'd2,   4'h0, 32'h0,        1'b0, 32'h22,       32'h22,       1'b0, 0});
    vt.push_back('{1'b0, 8'd3,   4'h0, 32'h0,        1'b0, 32'h33,       32'h33,       1'b0, 0});
    vt.push_back('{1'b0, 8'd4,   4'h0, 32'h0,        1'b0, 32'h44,       32'h44,       1'b0, 4});
    vt.push_back('{1'b1, 8'd199, 4'hF, 32'h0BADF00D, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b1, 8'd200, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b0, 8'd200, 4'h0, 32'h0,        1'b0, 32'hFFFFFFFF, 32'h0,        1'b0, 0});
    vt.push_back('{1'b0, 8'd199, 4'h0, 32'h0,        1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 4});
    vt.push_back('{1'b1, 8'd9,   4'h0, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b0, 8'd9,   4'h0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 4});
    vt.push_back('{1'b1, 8'd10,  4'hF, 32'h12345678, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b1, 8'd10,  4'hA, 32'hAABBCCDD, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b0, 8'd10,  4'h0, 32'h0,        1'b0, 32'hAA34CC78, 32'hAA34CC78, 1'b0, 4});
    vt.push_back('{1'b1, 8'd255, 4'hF, 32'h55,       1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b0, 8'd255, 4'h0, 32'h0,        1'b0, 32'h55,       32'h0,        1'b0, 4});
    vt.push_back('{1'b1, 8'd7,   4'hF, 32'hA5A5A5A5, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b1, 8'd7,   4'h1, 32'hA5A5A5A5, 1'b1, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b0, 8'd7,   4'h0, 32'h0,        1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, PE,   4});
    vt.push_back('{1'b1, 8'd7,   4'hF, 32'hA5A5A5A5, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vt.push_back('{1'b0, 8'd7,   4'h0, 32'h0,        1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 6});

    // A read of 0x80 is held across the whole sweep and must complete only once each side is READY.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h80; exp_a = '0; exp_b = '0; pe_row = 1'b0;
    repeat (3) @(negedge clock);
    chk_reset("rst0");
    run_sweep(400, ca, cb, nv, nr);
    chk("sweep0_len_a", ca, 256);
    chk("sweep0_len_b", cb, 200);
    chk("sweep0_vld_busy", nv, 0);
    chk("sweep0_rdy_busy", nr, 0);
    @(negedge clock);
    req_valid = 1'b0;
    repeat (6) @(negedge clock);

    foreach (vt[i]) begin
      @(negedge clock);
      req_valid = 1'b1; req_we = vt[i].we; req_addr = vt[i].addr; req_be = vt[i].be;
      req_wdata = vt[i].wd; err_inject = vt[i].err;
      exp_a = vt[i].ea; exp_b = vt[i].eb; pe_row = vt[i].pe;
      repeat (vt[i].gap) begin
        @(negedge clock);
        req_valid = 1'b0; err_inject = 1'b0;
      end
    end
    @(negedge clock);
    req_valid = 1'b0; err_inject = 1'b0;
    @(negedge clock);
    chk1("hold_vld_a", vld_a, 1'b0);
    chk("hold_rdat_a", rdat_a, 32'hA5A5A5A5);
    chk1("hold_vld_b", vld_b, 1'b0);
    chk("hold_rdat_b", rdat_b, 32'hA5A5A5A5);

    // Two reads in flight, then reset: neither may produce a response.
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5; exp_a = 32'hDEAD1234; exp_b = 32'hDEAD1234;
    pe_row = 1'b0;
    @(negedge clock);
    req_addr = 8'd1; exp_a = 32'h11; exp_b = 32'h11;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clock);
    chk_reset("rst1");
    win = 0;
    repeat (4) begin
      @(negedge clock);
      if (vld_a || vld_b) win++;
    end
    chk("inflight_discard", win, 0);

    run_sweep(100, ca, cb, nv, nr);
    chk("sweep1_vld_busy", nv, 0);
    reset_n = 1'b0;
    @(negedge clock);
    chk_reset("rst2");
    run_sweep(400, ca, cb, nv, nr);
    chk("sweep2_len_a", ca, 256);
    chk("sweep2_len_b", cb, 200);
    chk("sweep2_vld_busy", nv, 0);
    chk("sweep2_rdy_busy", nr, 0);

    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd5; exp_a = '0; exp_b = '0; pe_row = 1'b0;
    @(negedge clock);
    req_valid = 1'b0;
    repeat (8) @(negedge clock);
    chk("q_a_drained", qa.size(), 0);
    chk("q_b_drained", qb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
